wb_trace_buffer: RTL and testbench
==================================

WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 8, number of FIFO entries; power of two, minimum 4.
REQ-002 Port clk, input, 1, single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1, synchronous active-high reset.
REQ-004 Port pc, input, 32, PC of the instruction committing this cycle.
REQ-005 Port grf_we, input, 1, register-file write strobe.
REQ-006 Port grf_addr, input, 5, destination register.
REQ-007 Port grf_wdata, input, 32, register write data.
REQ-008 Port dm_we, input, 1, data-memory write strobe.
REQ-009 Port dm_addr, input, 32, byte address of the memory write.
REQ-010 Port dm_wdata, input, 32, memory write data.
REQ-011 Port trace_ready, input, 1, consumer accepts the head entry.
REQ-012 Port trace_valid, output, 1, head entry available.
REQ-013 Port trace_kind, output, 1, 0 = register write, 1 = memory write.
REQ-014 Port trace_pc / trace_addr / trace_data, output, 32 each; addr is zero-extended grf_addr for kind 0.
REQ-015 Port count, output, clog2(DEPTH)+1, current occupancy.
REQ-016 Port overflow, output, 1, sticky flag: an event was dropped.
REQ-017 Port drop_cnt, output, 8, saturating count of dropped events.

Function
REQ-018 Event capture: grf_we=1 with grf_addr!=0 SHALL generate a kind-0 event; grf_we=1 with grf_addr=0 SHALL be discarded silently. It SHALL NOT count as a drop.
REQ-019 Event capture: dm_we=1 SHALL generate a kind-1 event.
REQ-020 Events SHALL be written in the cycle they are presented. They SHALL be visible on trace_valid no earlier than the next cycle, giving 1-cycle push-to-valid latency.
REQ-021 Handshake: an entry is popped on a rising edge with trace_valid=1 and trace_ready=1. Outputs SHALL hold stable while trace_valid=1 and trace_ready=0.
REQ-022 trace_valid SHALL equal (count != 0). Output fields SHALL reflect the head entry combinationally from storage.
REQ-023 Simultaneous register and memory events: both SHALL be enqueued, with kind 0 ahead of kind 1, only if two slots are free after this cycle's pop.
REQ-024 If two events arrive but only one slot is free, the kind-0 event SHALL be enqueued and the kind-1 event dropped.
REQ-025 Free-slot rule: free = DEPTH - count + (pop this cycle ? 1 : 0). A pop while full SHALL admit a push in the same cycle.
REQ-026 Each dropped event SHALL set overflow and increment drop_cnt, which saturates at 255. Two drops in one cycle SHALL add 2, saturating.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH. count SHALL update by pushes minus pop, with a range of 0..DEPTH.
REQ-028 trace_ready while empty SHALL have no effect.

Reset
REQ-029 When reset=1 at a clock edge: pointers=0, count=0, trace_valid=0, overflow=0, drop_cnt=0. Storage contents are don't-care.
REQ-030 Events presented in a reset cycle SHALL be discarded and SHALL NOT be counted as drops.
REQ-031 Reset asserted mid-stream SHALL discard all queued entries within that edge.

Structure
REQ-032 Shared package trace_pkg SHALL hold KIND_GRF=0, KIND_DM=1, the entry width (1+32+32+32=97) and the entry field offsets.
REQ-033 Storage SHALL be one sub-module, trace_fifo_mem: a dual-write-port / single-read-port register array indexed by wr_ptr and wr_ptr+1. Capture, drop and handshake logic stay in wb_trace_buffer.

Verification
REQ-034 Stimulus: grf_we=1, grf_addr=8, grf_wdata=0x1234, pc=0x3000, with trace_ready=1. Response: next cycle, valid=1, kind=0, pc=0x3000, addr=8, data=0x1234; popped, then count=0.
REQ-035 Stimulus: grf_we=1 with grf_addr=0, 5 cycles. Response: count stays 0, overflow=0, drop_cnt=0.
REQ-036 Stimulus: trace_ready=0; 10 consecutive dm_we events with DEPTH=8, addr 0x0..0x24 step 4. Response: count=8, overflow=1, drop_cnt=2. Drain yields addrs 0x0..0x1C in order.
REQ-037 Stimulus: count=7, trace_ready=0, one cycle with both grf_we (addr 3) and dm_we. Response: kind-0 entry stored, count=8, drop_cnt=1. With trace_ready=1 instead: both stored, count=8, drop_cnt=0.
REQ-038 Stimulus: full FIFO, trace_ready=1 plus one dm_we for 20 cycles. Response: count stays 8, overflow stays 0, order preserved across pointer wrap.
REQ-039 Stimulus: 5 entries queued, overflow=1, then reset for one cycle. Response: trace_valid=0, count=0, overflow=0, drop_cnt=0 on the following cycle.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared definitions for the commit trace buffer: event kinds and the
// packed layout of one stored trace entry.
package trace_pkg;

    localparam logic KIND_GRF = 1'b0;
    localparam logic KIND_DM  = 1'b1;

    localparam int FIELD_W  = 32;
    localparam int ENTRY_W  = 1 + 3 * FIELD_W;

    // Entry layout, MSB first: kind | pc | addr | data
    localparam int DATA_LSB = 0;
    localparam int ADDR_LSB = DATA_LSB + FIELD_W;
    localparam int PC_LSB   = ADDR_LSB + FIELD_W;
    localparam int KIND_BIT = PC_LSB + FIELD_W;

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic              kind,
        input logic [FIELD_W-1:0] pc,
        input logic [FIELD_W-1:0] addr,
        input logic [FIELD_W-1:0] data
    );
        logic [ENTRY_W-1:0] e;
        e                       = '0;
        e[KIND_BIT]             = kind;
        e[PC_LSB   +: FIELD_W]  = pc;
        e[ADDR_LSB +: FIELD_W]  = addr;
        e[DATA_LSB +: FIELD_W]  = data;
        return e;
    endfunction

endpackage

// File: rtl/trace_fifo_mem.sv
// Trace entry storage: two write ports at wr_ptr and wr_ptr+1 so a register
// and a memory event from the same commit can land together; one async read port.
module trace_fifo_mem
    import trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic [$clog2(DEPTH)-1:0]   wr_ptr,
    input  logic                       we0,
    input  logic [ENTRY_W-1:0]         wdata0,
    input  logic                       we1,
    input  logic [ENTRY_W-1:0]         wdata1,
    input  logic [$clog2(DEPTH)-1:0]   rd_ptr,
    output logic [ENTRY_W-1:0]         rdata
);

    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr_next;

    // Power-of-two depth makes the natural pointer overflow the wrap.
    assign wr_ptr_next = wr_ptr + AW'(1);

    always_ff @(posedge clk) begin
        if (we0) mem[wr_ptr]      <= wdata0;
        if (we1) mem[wr_ptr_next] <= wdata1;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/wb_trace_buffer.sv
// Write-back trace buffer: captures register-file and data-memory writes of
// committing instructions into a FIFO drained by a valid/ready consumer.
module wb_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                pc,
    input  logic                       grf_we,
    input  logic [4:0]                 grf_addr,
    input  logic [31:0]                grf_wdata,
    input  logic                       dm_we,
    input  logic [31:0]                dm_addr,
    input  logic [31:0]                dm_wdata,
    input  logic                       trace_ready,
    output logic                       trace_valid,
    output logic                       trace_kind,
    output logic [31:0]                trace_pc,
    output logic [31:0]                trace_addr,
    output logic [31:0]                trace_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("wb_trace_buffer: DEPTH must be a power of two, at least 4");
    end

    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      occ;
    logic               ovf;
    logic [7:0]         drops;

    logic               pop;
    logic               grf_ev;
    logic               dm_ev;
    logic [CW-1:0]      free_slots;
    logic [CW-1:0]      dm_need;
    logic               push_grf;
    logic               push_dm;
    logic [1:0]         n_push;
    logic [1:0]         n_drop;
    logic [8:0]         drop_sum;
    logic [7:0]         drop_next;

    logic               we0;
    logic               we1;
    logic [ENTRY_W-1:0] wdata0;
    logic [ENTRY_W-1:0] wdata1;
    logic [ENTRY_W-1:0] grf_entry;
    logic [ENTRY_W-1:0] dm_entry;
    logic [ENTRY_W-1:0] head;

    assign pop    = (occ != '0) && trace_ready;
    assign grf_ev = grf_we && (grf_addr != 5'd0);
    assign dm_ev  = dm_we;

    // A pop this cycle frees its slot in time for a same-cycle push.
    assign free_slots = CW'(DEPTH) - occ + CW'(pop);

    assign grf_entry = pack_entry(KIND_GRF, pc, {27'd0, grf_addr}, grf_wdata);
    assign dm_entry  = pack_entry(KIND_DM, pc, dm_addr, dm_wdata);

    // The register event always claims the first slot; the memory event
    // needs a second one when both arrive together.
    always_comb begin
        dm_need  = grf_ev ? CW'(2) : CW'(1);
        push_grf = grf_ev && (free_slots != '0);
        push_dm  = dm_ev && (free_slots >= dm_need);
        n_push   = {1'b0, push_grf} + {1'b0, push_dm};
        n_drop   = {1'b0, grf_ev && !push_grf} + {1'b0, dm_ev && !push_dm};
    end

    always_comb begin
        we0    = 1'b0;
        we1    = 1'b0;
        wdata0 = grf_entry;
        wdata1 = dm_entry;
        if (push_grf) begin
            we0 = 1'b1;
            we1 = push_dm;
        end else if (push_dm) begin
            we0    = 1'b1;
            wdata0 = dm_entry;
        end
    end

    assign drop_sum  = {1'b0, drops} + 9'(n_drop);
    assign drop_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            ovf    <= 1'b0;
            drops  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(n_push);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            occ    <= occ + CW'(n_push) - CW'(pop);
            if (n_drop != 2'd0) ovf <= 1'b1;
            drops  <= drop_next;
        end
    end

    trace_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk    (clk),
        .wr_ptr (wr_ptr),
        .we0    (we0),
        .wdata0 (wdata0),
        .we1    (we1),
        .wdata1 (wdata1),
        .rd_ptr (rd_ptr),
        .rdata  (head)
    );

    assign trace_valid = (occ != '0);
    assign trace_kind  = head[KIND_BIT];
    assign trace_pc    = head[PC_LSB   +: FIELD_W];
    assign trace_addr  = head[ADDR_LSB +: FIELD_W];
    assign trace_data  = head[DATA_LSB +: FIELD_W];
    assign count       = occ;
    assign overflow    = ovf;
    assign drop_cnt    = drops;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Scoreboard bench for wb_trace_buffer: a queue-based model predicts the trace
// stream and a monitor checks every handshake plus occupancy and drop status.
module tb_wb_trace_buffer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        grf_we;
    logic [4:0]  grf_addr;
    logic [31:0] grf_wdata;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        trace_ready;
    logic        trace_valid;
    logic        trace_kind;
    logic [31:0] trace_pc;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;
    logic [3:0]  count;
    logic        overflow;
    logic [7:0]  drop_cnt;

    typedef struct {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t  expQ[$];
    int   expCount = 0;
    logic expOvf = 1'b0;
    int   expDrops = 0;
    logic modelOvf = 1'b0;
    int   modelDrops = 0;
    bit   armed = 1'b0;
    int   checks = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    wb_trace_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .grf_we      (grf_we),
        .grf_addr    (grf_addr),
        .grf_wdata   (grf_wdata),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .trace_ready (trace_ready),
        .trace_valid (trace_valid),
        .trace_kind  (trace_kind),
        .trace_pc    (trace_pc),
        .trace_addr  (trace_addr),
        .trace_data  (trace_data),
        .count       (count),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of stimulus and advances the reference model: events
    // are taken in order (register first), each needing one free slot, where
    // free slots = DEPTH - occupancy + (pop this cycle).
    task automatic applyStimulus(
        input logic rst, input logic gwe, input logic [4:0] ga, input logic [31:0] gd,
        input logic dwe, input logic [31:0] da, input logic [31:0] dd,
        input logic [31:0] pcv, input logic rdy
    );
        int  freeSlots;
        int  lost;
        ev_t e;
        @(negedge clk);
        expCount = expQ.size();
        expOvf   = modelOvf;
        expDrops = modelDrops;
        reset = rst; grf_we = gwe; grf_addr = ga; grf_wdata = gd;
        dm_we = dwe; dm_addr = da; dm_wdata = dd; pc = pcv; trace_ready = rdy;
        if (rst) begin
            expQ.delete();
            modelOvf   = 1'b0;
            modelDrops = 0;
        end else begin
            freeSlots = DEPTH - expCount + ((expCount > 0 && rdy) ? 1 : 0);
            lost = 0;
            if (gwe && ga != 5'd0) begin
                if (freeSlots > 0) begin
                    e.kind = 1'b0; e.pc = pcv; e.addr = {27'd0, ga}; e.data = gd;
                    expQ.push_back(e);
                    freeSlots--;
                end else lost++;
            end
            if (dwe) begin
                if (freeSlots > 0) begin
                    e.kind = 1'b1; e.pc = pcv; e.addr = da; e.data = dd;
                    expQ.push_back(e);
                    freeSlots--;
                end else lost++;
            end
            if (lost > 0) modelOvf = 1'b1;
            modelDrops = (modelDrops + lost > 255) ? 255 : modelDrops + lost;
        end
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, rdy);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic dmWrite(input logic [31:0] a, input logic [31:0] d, input logic rdy);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, a, d, 32'h4000 + a, rdy);
    endtask

    // Monitor: compares status every cycle and the head entry on each handshake.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            #2;
            if (armed) begin
                checkOutput("valid", {31'd0, trace_valid}, {31'd0, expCount != 0});
                checkOutput("count", {28'd0, count}, expCount);
                checkOutput("overflow", {31'd0, overflow}, {31'd0, expOvf});
                checkOutput("drop_cnt", {24'd0, drop_cnt}, expDrops);
                if (trace_valid && trace_ready && !reset && expCount > 0) begin
                    e = expQ.pop_front();
                    checkOutput("head_kind", {31'd0, trace_kind}, {31'd0, e.kind});
                    checkOutput("head_pc", trace_pc, e.pc);
                    checkOutput("head_addr", trace_addr, e.addr);
                    checkOutput("head_data", trace_data, e.data);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; pc = '0; grf_we = 1'b0; grf_addr = '0; grf_wdata = '0;
        dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; trace_ready = 1'b0;
        doReset();
        doReset();
        armed = 1'b1;

        // Single register write, consumed immediately
        idle(1'b0);
        #3;
        checkOutput("reset_valid", {31'd0, trace_valid}, 32'd0);
        checkOutput("reset_count", {28'd0, count}, 32'd0);
        applyStimulus(1'b0, 1'b1, 5'd8, 32'h1234, 1'b0, 32'd0, 32'd0, 32'h3000, 1'b1);
        idle(1'b1);
        #3;
        checkOutput("reg_valid", {31'd0, trace_valid}, 32'd1);
        checkOutput("reg_kind", {31'd0, trace_kind}, 32'd0);
        checkOutput("reg_pc", trace_pc, 32'h3000);
        checkOutput("reg_addr", trace_addr, 32'd8);
        checkOutput("reg_data", trace_data, 32'h1234);
        idle(1'b1);
        #3;
        checkOutput("reg_popped_count", {28'd0, count}, 32'd0);

        // Writes to register zero vanish without being drops
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 1'b1, 5'd0, 32'hDEAD0000 + i, 1'b0, 32'd0, 32'd0, 32'h3100, 1'b0);
        idle(1'b0);
        #3;
        checkOutput("r0_count", {28'd0, count}, 32'd0);
        checkOutput("r0_overflow", {31'd0, overflow}, 32'd0);
        checkOutput("r0_drops", {24'd0, drop_cnt}, 32'd0);

        // Overfill with memory writes, then drain in order
        doReset();
        for (int i = 0; i < 10; i++) dmWrite(32'(4 * i), 32'hA000 + i, 1'b0);
        idle(1'b0);
        #3;
        checkOutput("fill_count", {28'd0, count}, 32'd8);
        checkOutput("fill_overflow", {31'd0, overflow}, 32'd1);
        checkOutput("fill_drops", {24'd0, drop_cnt}, 32'd2);
        checkOutput("fill_head_addr", trace_addr, 32'h0);
        for (int i = 0; i < 8; i++) idle(1'b1);

        // Dual event with one free slot: memory event is dropped
        doReset();
        for (int i = 0; i < 7; i++) dmWrite(32'h100 + 32'(4 * i), i, 1'b0);
        applyStimulus(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 32'h200, 32'h44, 32'h5000, 1'b0);
        idle(1'b0);
        #3;
        checkOutput("dual_full_count", {28'd0, count}, 32'd8);
        checkOutput("dual_full_drops", {24'd0, drop_cnt}, 32'd1);
        for (int i = 0; i < 8; i++) idle(1'b1);

        // Dual event with a same-cycle pop: both fit
        doReset();
        for (int i = 0; i < 7; i++) dmWrite(32'h100 + 32'(4 * i), i, 1'b0);
        applyStimulus(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 32'h200, 32'h44, 32'h5000, 1'b1);
        idle(1'b0);
        #3;
        checkOutput("dual_pop_count", {28'd0, count}, 32'd8);
        checkOutput("dual_pop_drops", {24'd0, drop_cnt}, 32'd0);
        for (int i = 0; i < 8; i++) idle(1'b1);

        // Full FIFO streaming through pointer wrap
        doReset();
        for (int i = 0; i < 8; i++) dmWrite(32'h800 + 32'(4 * i), 32'hB00 + i, 1'b0);
        for (int i = 8; i < 28; i++) dmWrite(32'h800 + 32'(4 * i), 32'hB00 + i, 1'b1);
        idle(1'b0);
        #3;
        checkOutput("stream_count", {28'd0, count}, 32'd8);
        checkOutput("stream_overflow", {31'd0, overflow}, 32'd0);
        checkOutput("stream_head_addr", trace_addr, 32'h800 + 32'(4 * 20));
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Mid-stream reset clears everything
        for (int i = 0; i < 4; i++) dmWrite(32'h900 + 32'(4 * i), i, 1'b0);
        idle(1'b0);
        #3;
        checkOutput("pre_reset_count", {28'd0, count}, 32'd8);
        checkOutput("pre_reset_overflow", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 3; i++) idle(1'b1);
        applyStimulus(1'b1, 1'b1, 5'd7, 32'h77, 1'b1, 32'h77, 32'h77, 32'h77, 1'b1);
        idle(1'b0);
        #3;
        checkOutput("post_reset_valid", {31'd0, trace_valid}, 32'd0);
        checkOutput("post_reset_count", {28'd0, count}, 32'd0);
        checkOutput("post_reset_overflow", {31'd0, overflow}, 32'd0);
        checkOutput("post_reset_drops", {24'd0, drop_cnt}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic [4:0] ga;
            ga = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            applyStimulus($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)), ga, $urandom,
                          1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                          $urandom_range(0, 2) != 0 ? 1'($urandom_range(0, 1)) : 1'b1);
        end
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
        #3;
        checkOutput("final_count", {28'd0, count}, 32'd0);

        @(negedge clk);
        #4;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
